vic_nest_ctrl: RTL and testbench

VIC_NEST_CTRL -- requirements
Module: vic_nest_ctrl

---
 rtl/vic_nest_ctrl.sv | 96 +++++++++
 tb/tb_vic_nest_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vic_nest_ctrl.sv
// vic_nest_ctrl: vectored IRQ priority controller with an in-service nesting stack.
// Define VIC_NEST_EN for a NEST_DEPTH-entry stack; otherwise effective depth is 1.
module vic_nest_ctrl #(
    parameter int NEST_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] vect_req,
    input  logic        nv_req,
    input  logic        irq_ack,
    input  logic        vect_done,
    output logic        irq_n,
    output logic [3:0]  handler_num,
    output logic        is_nv,
    output logic [4:0]  cur_level,
    output logic [3:0]  depth,
    output logic        nest_err
);
    localparam int IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
`ifdef VIC_NEST_EN
    localparam logic [3:0] MaxDepth = 4'(NEST_DEPTH);
`else
    localparam logic [3:0] MaxDepth = 4'd1;
`endif

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK_CLR} state_t;

    state_t        state;
    logic [4:0]    stack [NEST_DEPTH];
    logic [4:0]    pendLevel;
    logic          pendValid;
    logic          eligible;
    logic          ackValid;
    logic          doPop;
    logic [4:0]    ackLevel;
    logic [IW-1:0] topIdx;
    logic [IW-1:0] pushIdx;

    // Lowest set slot wins; level 16 stands for the non-vectored request.
    always_comb begin
        pendLevel = 5'd16;
        for (int i = 15; i >= 0; i--)
            if (vect_req[i]) pendLevel = 5'(i);
    end

    assign pendValid = (|vect_req) || nv_req;
    assign topIdx    = IW'(depth - 4'd1);
    assign pushIdx   = IW'(depth);
    assign cur_level = (depth == 4'd0) ? 5'd31 : stack[topIdx];
`ifdef VIC_NEST_EN
    assign eligible  = pendValid && (pendLevel < cur_level);
`else
    assign eligible  = pendValid && (pendLevel < cur_level) && (depth == 4'd0);
`endif
    assign ackValid  = (state == ASSERT) && irq_ack;
    assign doPop     = vect_done && (depth != 4'd0);
    assign ackLevel  = is_nv ? 5'd16 : {1'b0, handler_num};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            irq_n       <= 1'b1;
            handler_num <= 4'd0;
            is_nv       <= 1'b0;
            depth       <= 4'd0;
            nest_err    <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= 5'd31;
        end else begin
            if (ackValid) begin
                state <= WAIT_ACK_CLR;
                irq_n <= 1'b1;
            end else if (state != WAIT_ACK_CLR && eligible) begin
                state       <= ASSERT;
                irq_n       <= 1'b0;
                handler_num <= pendLevel[4] ? 4'd0 : pendLevel[3:0];
                is_nv       <= pendLevel[4];
            end else begin
                state <= IDLE;
                irq_n <= 1'b1;
            end
            // A simultaneous ack and done replaces the top, so depth is unchanged.
            if (ackValid && doPop) begin
                stack[topIdx] <= ackLevel;
            end else if (ackValid && depth == MaxDepth) begin
                nest_err <= 1'b1;
            end else if (ackValid) begin
                stack[pushIdx] <= ackLevel;
                depth          <= depth + 4'd1;
            end else if (doPop) begin
                stack[topIdx] <= 5'd31;
                depth         <= depth - 4'd1;
            end
            if (vect_done && depth == 4'd0) nest_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vic_nest_ctrl.sv
// tb_vic_nest_ctrl: table-driven and sequence checks for vic_nest_ctrl.
module tb_vic_nest_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] vect_req;
    logic        nv_req;
    logic        irq_ack;
    logic        vect_done;
    logic        irq_n;
    logic [3:0]  handler_num;
    logic        is_nv;
    logic [4:0]  cur_level;
    logic [3:0]  depth;
    logic        nest_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] vreq;
        logic        nv;
        logic        expIrqN;
        logic [3:0]  expHandler;
        logic        expNv;
    } vec_t;

    vec_t tbl [11];
    vec_t sbq [$];
    vec_t exp;

    vic_nest_ctrl #(.NEST_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .vect_req(vect_req), .nv_req(nv_req),
        .irq_ack(irq_ack), .vect_done(vect_done), .irq_n(irq_n),
        .handler_num(handler_num), .is_nv(is_nv), .cur_level(cur_level),
        .depth(depth), .nest_err(nest_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic pushLevel(input int lvl, input int expDepth);
        vect_req = 16'd1 << lvl;
        tick();
        chk("push irq_n", int'(irq_n), 0);
        chk("push handler", int'(handler_num), lvl);
        irq_ack = 1'b1;
        tick();
        irq_ack  = 1'b0;
        vect_req = 16'd0;
        chk("push depth", int'(depth), expDepth);
        chk("push cur_level", int'(cur_level), lvl);
        chk("push irq_n clr", int'(irq_n), 1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; vect_req = 16'd0; nv_req = 1'b0; irq_ack = 1'b0; vect_done = 1'b0;
        #12;
        chk("rst irq_n", int'(irq_n), 1);
        chk("rst handler", int'(handler_num), 0);
        chk("rst is_nv", int'(is_nv), 0);
        chk("rst depth", int'(depth), 0);
        chk("rst cur_level", int'(cur_level), 31);
        chk("rst nest_err", int'(nest_err), 0);
        tick();
        rst = 1'b0;

        tbl[0]  = '{16'h0008, 1'b0, 1'b0, 4'd3,  1'b0};
        tbl[1]  = '{16'h0001, 1'b0, 1'b0, 4'd0,  1'b0};
        tbl[2]  = '{16'h8000, 1'b0, 1'b0, 4'd15, 1'b0};
        tbl[3]  = '{16'h0000, 1'b1, 1'b0, 4'd0,  1'b1};
        tbl[4]  = '{16'h0006, 1'b0, 1'b0, 4'd1,  1'b0};
        tbl[5]  = '{16'hFFFF, 1'b1, 1'b0, 4'd0,  1'b0};
        tbl[6]  = '{16'h0000, 1'b0, 1'b1, 4'd0,  1'b0};
        tbl[7]  = '{16'h0400, 1'b1, 1'b0, 4'd10, 1'b0};
        tbl[8]  = '{16'h0000, 1'b0, 1'b1, 4'd10, 1'b0};
        tbl[9]  = '{16'h0000, 1'b1, 1'b0, 4'd0,  1'b1};
        tbl[10] = '{16'h0000, 1'b0, 1'b1, 4'd0,  1'b1};
        for (int i = 0; i < 11; i++) begin
            vect_req = tbl[i].vreq;
            nv_req   = tbl[i].nv;
            sbq.push_back(tbl[i]);
            tick();
            exp = sbq.pop_front();
            chk($sformatf("row%0d irq_n", i), int'(irq_n), int'(exp.expIrqN));
            chk($sformatf("row%0d handler", i), int'(handler_num), int'(exp.expHandler));
            chk($sformatf("row%0d is_nv", i), int'(is_nv), int'(exp.expNv));
            vect_req = 16'd0;
            nv_req   = 1'b0;
            tick();
            chk($sformatf("row%0d withdrawn irq_n", i), int'(irq_n), 1);
        end

        pushLevel(3, 1);
`ifdef VIC_NEST_EN
        pushLevel(1, 2);
        vect_done = 1'b1;
        tick();
        vect_done = 1'b0;
        chk("pop depth", int'(depth), 1);
        chk("pop cur_level", int'(cur_level), 3);
        vect_req = 16'h0020;
        nv_req   = 1'b1;
        tick();
        chk("blocked irq_n", int'(irq_n), 1);
        vect_done = 1'b1;
        tick();
        vect_done = 1'b0;
        chk("pop2 depth", int'(depth), 0);
        chk("pop2 cur_level", int'(cur_level), 31);
        chk("pop2 irq_n", int'(irq_n), 1);
        tick();
        chk("after pop irq_n", int'(irq_n), 0);
        chk("after pop handler", int'(handler_num), 5);
        chk("after pop is_nv", int'(is_nv), 0);
        vect_req = 16'd0;
        nv_req   = 1'b0;
        tick();
        pushLevel(3, 1);
        pushLevel(1, 2);
        vect_req = 16'h0001;
        tick();
        chk("swap irq_n", int'(irq_n), 0);
        irq_ack   = 1'b1;
        vect_done = 1'b1;
        tick();
        irq_ack   = 1'b0;
        vect_done = 1'b0;
        vect_req  = 16'd0;
        chk("swap depth", int'(depth), 2);
        chk("swap cur_level", int'(cur_level), 0);
        chk("swap nest_err", int'(nest_err), 0);
        tick();
        doReset();
        pushLevel(8, 1);
        pushLevel(6, 2);
        pushLevel(4, 3);
        pushLevel(2, 4);
        vect_req = 16'h0001;
        tick();
        chk("ovf irq_n", int'(irq_n), 0);
        irq_ack = 1'b1;
        tick();
        irq_ack  = 1'b0;
        vect_req = 16'd0;
        chk("ovf depth", int'(depth), 4);
        chk("ovf nest_err", int'(nest_err), 1);
        chk("ovf cur_level", int'(cur_level), 2);
        chk("ovf irq_n clr", int'(irq_n), 1);
        tick();
`else
        vect_req = 16'h0002;
        tick();
        chk("single blocked irq_n", int'(irq_n), 1);
        vect_done = 1'b1;
        tick();
        vect_done = 1'b0;
        chk("single pop depth", int'(depth), 0);
        chk("single pop irq_n", int'(irq_n), 1);
        tick();
        chk("single after pop irq_n", int'(irq_n), 0);
        chk("single after pop handler", int'(handler_num), 1);
        irq_ack = 1'b1;
        tick();
        irq_ack  = 1'b0;
        vect_req = 16'd0;
        chk("single ack depth", int'(depth), 1);
        chk("single ack cur_level", int'(cur_level), 1);
        tick();
`endif
        doReset();
        chk("reset clears nest_err", int'(nest_err), 0);
        vect_done = 1'b1;
        tick();
        vect_done = 1'b0;
        chk("udf nest_err", int'(nest_err), 1);
        chk("udf depth", int'(depth), 0);
        chk("udf cur_level", int'(cur_level), 31);
        tick();
        chk("udf sticky", int'(nest_err), 1);

        doReset();
`ifdef VIC_NEST_EN
        pushLevel(8, 1);
        pushLevel(6, 2);
`endif
        vect_req = 16'h0010;
        tick();
        chk("pre-rst irq_n", int'(irq_n), 0);
        chk("pre-rst handler", int'(handler_num), 4);
        rst = 1'b1;
        #1;
        chk("async rst irq_n", int'(irq_n), 1);
        chk("async rst depth", int'(depth), 0);
        chk("async rst cur_level", int'(cur_level), 31);
        chk("async rst handler", int'(handler_num), 0);
        #1;
        rst = 1'b0;
        vect_req = 16'd0;
        tick();
        chk("post-rst irq_n", int'(irq_n), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
